// File: rtl/lru_cache_nway_pkg.sv
// Shared types, default geometry and address helper for the N-way LRU read cache.
package lru_cache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_MISS_REQ,
    ST_MISS_WAIT,
    ST_RESP
  } state_t;

  localparam int unsigned DEF_TAGS_WIDTH = 48;
  localparam int unsigned DEF_DATA_WIDTH = 64;
  localparam int unsigned DEF_LINE_WIDTH = 512;
  localparam int unsigned DEF_NUM_WAYS   = 8;
  localparam int unsigned DEF_NUM_SETS   = 4;

  localparam int unsigned DEF_W     = DEF_LINE_WIDTH / DEF_DATA_WIDTH;
  localparam int unsigned DEF_OFF_W = $clog2(DEF_W);
  localparam int unsigned DEF_SET_W = $clog2(DEF_NUM_SETS);
  localparam int unsigned DEF_TAG_W = DEF_TAGS_WIDTH - DEF_OFF_W - DEF_SET_W;

  // Word address to line address; callers size the result to their own width.
  function automatic logic [63:0] line_addr(input logic [63:0] addr, input int unsigned off_w);
    return addr >> off_w;
  endfunction

endpackage

// File: rtl/lru_cache_nway_if.sv
// Valid/ready stream bundle used for the cache's request, response and backend ports.
interface lru_cache_nway_if #(
  parameter int unsigned WIDTH = 64
);
  logic [WIDTH-1:0] tdata;
  logic             tvalid;
  logic             tready;

  modport master (output tdata, output tvalid, input  tready);
  modport slave  (input  tdata, input  tvalid, output tready);
endinterface

// File: rtl/lru_cache_nway_age_ctrl.sv
// True-LRU age update and victim choice for one set.
module lru_age_ctrl #(
  parameter int unsigned NUM_WAYS = 8,
  parameter int unsigned AGE_W    = 3
) (
  input  logic [NUM_WAYS*AGE_W-1:0] ages_in,
  input  logic [NUM_WAYS-1:0]       valid_in,
  input  logic [AGE_W-1:0]          access_way,
  output logic [NUM_WAYS*AGE_W-1:0] ages_out,
  output logic [AGE_W-1:0]          victim
);

  logic [AGE_W-1:0] old_age;
  logic             found;

  always_comb begin
    old_age  = ages_in[access_way*AGE_W +: AGE_W];
    ages_out = ages_in;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (AGE_W'(w) == access_way)
        ages_out[w*AGE_W +: AGE_W] = '0;
      else if (ages_in[w*AGE_W +: AGE_W] < old_age)
        ages_out[w*AGE_W +: AGE_W] = ages_in[w*AGE_W +: AGE_W] + 1'b1;
    end
  end

  // Lowest invalid way first; only once the set is full does age decide.
  always_comb begin
    victim = '0;
    found  = 1'b0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (!valid_in[w] && !found) begin
        victim = AGE_W'(w);
        found  = 1'b1;
      end
    end
    if (!found) begin
      for (int unsigned w = 0; w < NUM_WAYS; w++) begin
        if (ages_in[w*AGE_W +: AGE_W] == AGE_W'(NUM_WAYS - 1))
          victim = AGE_W'(w);
      end
    end
  end

endmodule

// File: rtl/lru_cache_nway.sv
// Blocking N-way set-associative read cache with true-LRU replacement.
// Optional hit/miss counters are enabled by defining LRU_CACHE_STATS_EN.
module lru_cache_nway
  import lru_cache_pkg::*;
#(
  parameter int unsigned TAGS_WIDTH = DEF_TAGS_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned LINE_WIDTH = DEF_LINE_WIDTH,
  parameter int unsigned NUM_WAYS   = DEF_NUM_WAYS,
  parameter int unsigned NUM_SETS   = DEF_NUM_SETS
) (
  input  logic             clk,
  input  logic             rst,
  lru_cache_nway_if.slave  fe_addr,
  lru_cache_nway_if.master fe_data,
  lru_cache_nway_if.master be_addr,
  lru_cache_nway_if.slave  be_data
`ifdef LRU_CACHE_STATS_EN
  ,
  output logic [31:0]      stat_hits,
  output logic [31:0]      stat_misses
`endif
);

  localparam int unsigned W      = LINE_WIDTH / DATA_WIDTH;
  localparam int unsigned OFF_W  = $clog2(W);
  localparam int unsigned SET_W  = $clog2(NUM_SETS);
  localparam int unsigned SIDX_W = (SET_W > 0) ? SET_W : 1;
  localparam int unsigned TAG_W  = TAGS_WIDTH - OFF_W - SET_W;
  localparam int unsigned AGE_W  = $clog2(NUM_WAYS);

  typedef logic [NUM_WAYS*AGE_W-1:0] ages_t;

  state_t state_q, state_d;

  logic [TAGS_WIDTH-1:0] addr_q;
  logic                  fe_addr_rdy_q, fe_data_vld_q, be_addr_vld_q, be_data_rdy_q;
  logic [DATA_WIDTH-1:0] fe_data_q;
  logic [TAGS_WIDTH-1:0] be_addr_q;

  logic [NUM_WAYS-1:0]   valid_q [NUM_SETS];
  ages_t                 age_q   [NUM_SETS];
  logic [TAG_W-1:0]      tag_q   [NUM_SETS][NUM_WAYS];
  logic [LINE_WIDTH-1:0] line_q  [NUM_SETS][NUM_WAYS];

  logic [TAGS_WIDTH-1:0] line_a;
  logic [SIDX_W-1:0]     set_idx;
  logic [TAG_W-1:0]      tag_w;
  logic [OFF_W-1:0]      off_w;

  logic                  hit;
  logic [AGE_W-1:0]      hit_way, victim, access_way;
  ages_t                 ages_upd;

  logic fe_addr_hs, fe_data_hs, be_addr_hs, be_data_hs;

  assign fe_addr.tready = fe_addr_rdy_q;
  assign fe_data.tvalid = fe_data_vld_q;
  assign fe_data.tdata  = fe_data_q;
  assign be_addr.tvalid = be_addr_vld_q;
  assign be_addr.tdata  = be_addr_q;
  assign be_data.tready = be_data_rdy_q;

  assign fe_addr_hs = fe_addr.tvalid && fe_addr_rdy_q;
  assign fe_data_hs = fe_data_vld_q && fe_data.tready;
  assign be_addr_hs = be_addr_vld_q && be_addr.tready;
  assign be_data_hs = be_data.tvalid && be_data_rdy_q;

  // Modulo by a power of two keeps the set index legal when NUM_SETS is 1.
  assign line_a  = TAGS_WIDTH'(line_addr(64'(addr_q), OFF_W));
  assign set_idx = SIDX_W'(line_a % TAGS_WIDTH'(NUM_SETS));
  assign tag_w   = addr_q[TAGS_WIDTH-1 -: TAG_W];
  assign off_w   = addr_q[OFF_W-1:0];

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[set_idx][w] && (tag_q[set_idx][w] == tag_w)) begin
        hit     = 1'b1;
        hit_way = AGE_W'(w);
      end
    end
  end

  assign access_way = (state_q == ST_MISS_WAIT) ? victim : hit_way;

  lru_age_ctrl #(
    .NUM_WAYS (NUM_WAYS),
    .AGE_W    (AGE_W)
  ) u_age_ctrl (
    .ages_in    (age_q[set_idx]),
    .valid_in   (valid_q[set_idx]),
    .access_way (access_way),
    .ages_out   (ages_upd),
    .victim     (victim)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (fe_addr_hs) state_d = ST_LOOKUP;
      ST_LOOKUP:    state_d = hit ? ST_RESP : ST_MISS_REQ;
      ST_MISS_REQ:  if (be_addr_hs) state_d = ST_MISS_WAIT;
      ST_MISS_WAIT: if (be_data_hs) state_d = ST_RESP;
      ST_RESP:      if (fe_data_hs) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state, so every one of
  // them stays low through reset and the first cycle after it.
  always_ff @(posedge clk) begin
    if (rst) begin
      fe_addr_rdy_q <= 1'b0;
      fe_data_vld_q <= 1'b0;
      be_addr_vld_q <= 1'b0;
      be_data_rdy_q <= 1'b0;
      fe_data_q     <= '0;
      be_addr_q     <= '0;
      addr_q        <= '0;
      for (int unsigned s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        for (int unsigned w = 0; w < NUM_WAYS; w++)
          age_q[s][w*AGE_W +: AGE_W] <= AGE_W'(w);
      end
    end else begin
      fe_addr_rdy_q <= (state_d == ST_IDLE);
      fe_data_vld_q <= (state_d == ST_RESP);
      be_addr_vld_q <= (state_d == ST_MISS_REQ);
      be_data_rdy_q <= (state_d == ST_MISS_WAIT);
      if (fe_addr_hs) addr_q <= fe_addr.tdata;
      if (state_q == ST_LOOKUP) begin
        if (hit) begin
          fe_data_q      <= line_q[set_idx][hit_way][off_w*DATA_WIDTH +: DATA_WIDTH];
          age_q[set_idx] <= ages_upd;
        end else begin
          be_addr_q <= line_a;
        end
      end
      if (be_data_hs) begin
        fe_data_q               <= be_data.tdata[off_w*DATA_WIDTH +: DATA_WIDTH];
        valid_q[set_idx][victim] <= 1'b1;
        age_q[set_idx]          <= ages_upd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && be_data_hs) begin
      line_q[set_idx][victim] <= be_data.tdata;
      tag_q[set_idx][victim]  <= tag_w;
    end
  end

`ifdef LRU_CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (state_q == ST_LOOKUP) begin
      if (hit) begin
        if (stat_hits != '1) stat_hits <= stat_hits + 32'd1;
      end else begin
        if (stat_misses != '1) stat_misses <= stat_misses + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lru_cache_nway.sv
// Directed plus randomized bench for lru_cache_nway against a recency-list cache model.
module tb_lru_cache_nway;

  localparam int unsigned TW = 48;
  localparam int unsigned DW = 64;
  localparam int unsigned LW = 512;
  localparam int unsigned NW = 8;
  localparam int unsigned NS = 4;
  localparam int unsigned WPL = LW / DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lru_cache_nway_if #(.WIDTH(TW)) fe_addr ();
  lru_cache_nway_if #(.WIDTH(DW)) fe_data ();
  lru_cache_nway_if #(.WIDTH(TW)) be_addr ();
  lru_cache_nway_if #(.WIDTH(LW)) be_data ();

`ifdef LRU_CACHE_STATS_EN
  logic [31:0] stat_hits, stat_misses;
`endif

  lru_cache_nway #(
    .TAGS_WIDTH (TW),
    .DATA_WIDTH (DW),
    .LINE_WIDTH (LW),
    .NUM_WAYS   (NW),
    .NUM_SETS   (NS)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .fe_addr (fe_addr),
    .fe_data (fe_data),
    .be_addr (be_addr),
    .be_data (be_data)
`ifdef LRU_CACHE_STATS_EN
    ,
    .stat_hits   (stat_hits),
    .stat_misses (stat_misses)
`endif
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Per-set recency list, most recently used first.
  longint unsigned m_lines [NS][NW];
  int unsigned     m_cnt   [NS];
  longint unsigned m_hits, m_misses;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] wordval(input longint unsigned ln, input int unsigned k);
    return (64'(ln) << 16) + 64'(k) + 64'h100;
  endfunction

  task automatic model_reset();
    for (int unsigned s = 0; s < NS; s++) m_cnt[s] = 0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic model_access(input longint unsigned ln, output bit is_hit);
    int unsigned s, pos;
    s      = int'(ln % NS);
    is_hit = 1'b0;
    pos    = 0;
    for (int unsigned i = 0; i < m_cnt[s]; i++)
      if (m_lines[s][i] == ln) begin is_hit = 1'b1; pos = i; end
    if (!is_hit) begin
      if (m_cnt[s] < NW) begin pos = m_cnt[s]; m_cnt[s]++; end
      else pos = NW - 1;
      m_misses++;
    end else begin
      m_hits++;
    end
    for (int unsigned j = pos; j > 0; j--) m_lines[s][j] = m_lines[s][j-1];
    m_lines[s][0] = ln;
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_fe_addr_tready"}, 64'(fe_addr.tready), 64'd0);
    chk({pfx, "_fe_data_tvalid"}, 64'(fe_data.tvalid), 64'd0);
    chk({pfx, "_be_addr_tvalid"}, 64'(be_addr.tvalid), 64'd0);
    chk({pfx, "_be_data_tready"}, 64'(be_data.tready), 64'd0);
    chk({pfx, "_fe_data_tdata"},  fe_data.tdata, 64'd0);
    chk({pfx, "_be_addr_tdata"},  64'(be_addr.tdata), 64'd0);
`ifdef LRU_CACHE_STATS_EN
    chk({pfx, "_stat_hits"},   64'(stat_hits), 64'd0);
    chk({pfx, "_stat_misses"}, 64'(stat_misses), 64'd0);
`endif
  endtask

  task automatic check_stats(input string pfx);
`ifdef LRU_CACHE_STATS_EN
    chk({pfx, "_stat_hits"},   64'(stat_hits), 64'(m_hits));
    chk({pfx, "_stat_misses"}, 64'(stat_misses), 64'(m_misses));
`else
    chk({pfx, "_idle_ready"}, 64'(fe_addr.tready), 64'd1);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fe_addr.tvalid = 1'b0;
    fe_data.tready = 1'b0;
    be_addr.tready = 1'b0;
    be_data.tvalid = 1'b0;
    repeat (2) step();
    check_reset_outputs("reset");
    rst = 1'b0;
    model_reset();
    step();
    chk("reset_release_tready", 64'(fe_addr.tready), 64'd1);
  endtask

  task automatic access(input logic [TW-1:0] a, input int unsigned stall, input int unsigned be_delay);
    longint unsigned ln;
    int unsigned     off, n, lat;
    bit              exp_hit;
    logic [63:0]     exp_w;
    logic [LW-1:0]   beat;
    ln  = longint'(a >> 3);
    off = int'(a[2:0]);
    fe_addr.tdata  = a;
    fe_addr.tvalid = 1'b1;
    n = 0;
    while (fe_addr.tready !== 1'b1 && n < 50) begin step(); n++; end
    chk("fe_addr_tready", 64'(fe_addr.tready), 64'd1);
    step();
    fe_addr.tvalid = 1'b0;
    model_access(ln, exp_hit);
    exp_w = wordval(ln, off);
    lat = 1;
    while (fe_data.tvalid !== 1'b1 && be_addr.tvalid !== 1'b1 && lat < 50) begin step(); lat++; end
    if (!exp_hit) begin
      chk("miss_be_addr_tvalid", 64'(be_addr.tvalid), 64'd1);
      chk("miss_be_addr_latency", 64'(lat), 64'd2);
      chk("miss_be_addr_tdata", 64'(be_addr.tdata), 64'(ln));
      chk("miss_be_data_tready_early", 64'(be_data.tready), 64'd0);
      for (int unsigned i = 0; i < be_delay; i++) begin
        step();
        chk("miss_be_addr_hold_valid", 64'(be_addr.tvalid), 64'd1);
        chk("miss_be_addr_hold_data", 64'(be_addr.tdata), 64'(ln));
      end
      be_addr.tready = 1'b1;
      step();
      be_addr.tready = 1'b0;
      for (int unsigned k = 0; k < WPL; k++) beat[k*DW +: DW] = wordval(ln, k);
      be_data.tdata  = beat;
      be_data.tvalid = 1'b1;
      n = 0;
      while (be_data.tready !== 1'b1 && n < 50) begin step(); n++; end
      chk("miss_be_data_tready", 64'(be_data.tready), 64'd1);
      step();
      be_data.tvalid = 1'b0;
      chk("miss_resp_tvalid", 64'(fe_data.tvalid), 64'd1);
    end else begin
      chk("hit_no_be_addr", 64'(be_addr.tvalid), 64'd0);
      chk("hit_latency", 64'(lat), 64'd2);
      chk("hit_resp_tvalid", 64'(fe_data.tvalid), 64'd1);
    end
    chk("resp_tdata", fe_data.tdata, exp_w);
    for (int unsigned i = 0; i < stall; i++) begin
      step();
      chk("stall_tvalid", 64'(fe_data.tvalid), 64'd1);
      chk("stall_tdata", fe_data.tdata, exp_w);
      chk("stall_fe_addr_tready", 64'(fe_addr.tready), 64'd0);
    end
    fe_data.tready = 1'b1;
    step();
    fe_data.tready = 1'b0;
    chk("resp_done_tvalid", 64'(fe_data.tvalid), 64'd0);
  endtask

  initial begin
    int unsigned n;
    logic [LW-1:0] beat;
    fe_addr.tdata  = '0;
    fe_addr.tvalid = 1'b0;
    fe_data.tready = 1'b0;
    be_addr.tready = 1'b0;
    be_data.tdata  = '0;
    be_data.tvalid = 1'b0;
    model_reset();

    do_reset();

    // Cold miss, hit, then a hit held under downstream backpressure.
    access(48'h0, 0, 0);
    access(48'h3, 0, 0);
    access(48'h5, 5, 0);

    // Fill set 0, refresh line 0, then force an eviction of line 32.
    do_reset();
    for (int unsigned i = 0; i < 8; i++) access(TW'(i * 32), 0, i % 3);
    access(48'h0, 0, 0);
    access(48'd256, 0, 0);
    access(48'd32, 0, 0);
    access(48'h0, 0, 0);
    check_stats("evict");

    // Reset while waiting for the line fill.
    fe_addr.tdata  = 48'h1000;
    fe_addr.tvalid = 1'b1;
    n = 0;
    while (fe_addr.tready !== 1'b1 && n < 50) begin step(); n++; end
    step();
    fe_addr.tvalid = 1'b0;
    n = 0;
    while (be_addr.tvalid !== 1'b1 && n < 50) begin step(); n++; end
    chk("midfill_be_addr_tvalid", 64'(be_addr.tvalid), 64'd1);
    be_addr.tready = 1'b1;
    step();
    be_addr.tready = 1'b0;
    chk("midfill_be_data_tready", 64'(be_data.tready), 64'd1);
    for (int unsigned k = 0; k < WPL; k++) beat[k*DW +: DW] = wordval(64'h200, k);
    be_data.tdata  = beat;
    be_data.tvalid = 1'b1;
    rst = 1'b1;
    step();
    check_reset_outputs("midfill");
    rst = 1'b0;
    be_data.tvalid = 1'b0;
    model_reset();
    step();
    chk("midfill_release_tready", 64'(fe_addr.tready), 64'd1);
    access(48'h1000, 0, 0);

    // Randomized mix over a footprint larger than the cache.
    for (int unsigned i = 0; i < 200; i++) begin
      logic [TW-1:0] a;
      a = TW'((longint'($urandom_range(0, 47)) << 3) | longint'($urandom_range(0, 7)));
      access(a, $urandom_range(0, 2), $urandom_range(0, 2));
    end
    check_stats("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
